// File: rtl/max_pool_stream.sv
// -----------------------------------------------------------------------------
// max_pool_stream
//
// Streaming max-pool reducer for the SPPF path. A KxK window of FP16 elements
// arrives as a sequence of LANES-wide beats. Each beat is reduced across its
// lanes, and the result is folded into a running accumulator. One maximum is
// emitted per window through a single registered output slot.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   cfg_k      : kernel side for the next window, sampled on its first beat
//   flush      : synchronous discard of a partially accumulated window
//   in_data    : LANES packed FP16 elements, lane 0 in the low bits (earliest)
//   in_valid   : input beat valid
//   in_ready   : input beat accepted when in_valid & in_ready
//   out_data   : window maximum (16'h7E00 if any counted element was NaN)
//   out_valid  : result valid, held until accepted
//   out_ready  : result consumed when out_valid & out_ready
//   busy       : high while a window is partially accumulated
// -----------------------------------------------------------------------------
module max_pool_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 9,
   parameter int MAX_K      = 13,
   parameter int CNT_W      = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [3:0]                  cfg_k,
   input  logic                        flush,
   input  logic [DATA_WIDTH*LANES-1:0] in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } state_t;

   localparam logic [3:0]            MAX_K4  = 4'(MAX_K);
   localparam logic [DATA_WIDTH-1:0] QNAN    = 16'h7E00;
   localparam logic [DATA_WIDTH-1:0] KEY_MIN = '0;

   // Monotonic ordering key: the unsigned order of keys matches the numeric
   // order of non-NaN FP16 values, with -0 sorting just below +0.
   function automatic logic [DATA_WIDTH-1:0] to_key(input logic [DATA_WIDTH-1:0] x);
      return x[15] ? ~x : (x ^ 16'h8000);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] from_key(input logic [DATA_WIDTH-1:0] k);
      return k[15] ? (k ^ 16'h8000) : ~k;
   endfunction

   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
   endfunction

   // Registered state
   state_t                  state_q,    state_d;
   logic [DATA_WIDTH-1:0]   acc_q,      acc_d;       // running max, key domain
   logic                    nan_q,      nan_d;
   logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]        beats_q,    beats_d;
   logic [CNT_W-1:0]        rem_q,      rem_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;

   // Combinational helpers
   logic [3:0]              keff;
   logic [CNT_W-1:0]        keff_w;
   logic [CNT_W-1:0]        n_cur;
   logic [CNT_W-1:0]        beats_cur;
   logic [CNT_W-1:0]        rem_cur;
   logic                    is_first;
   logic                    is_last;
   logic [CNT_W-1:0]        cur_rem;
   logic [DATA_WIDTH-1:0]   lane_val;
   logic [DATA_WIDTH-1:0]   lane_key;
   logic [DATA_WIDTH-1:0]   beat_key;
   logic                    beat_nan;
   logic [DATA_WIDTH-1:0]   merged_key;
   logic                    merged_nan;
   logic                    accept;

   assign in_ready  = ~out_valid_q | out_ready;
   assign accept    = in_valid & in_ready;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == S_ACCUM);

   // Window geometry from the live cfg_k; only used (and latched) on a
   // window's first beat, so later cfg_k changes have no effect.
   always_comb begin
      keff = cfg_k;
      if (cfg_k == 4'd0) begin
         keff = 4'd1;
      end else if (cfg_k > MAX_K4) begin
         keff = MAX_K4;
      end
      keff_w    = CNT_W'(keff);
      n_cur     = keff_w * keff_w;
      beats_cur = (n_cur + CNT_W'(LANES - 1)) / CNT_W'(LANES);
      rem_cur   = n_cur - (beats_cur - 1'b1) * CNT_W'(LANES);
   end

   // Per-beat lane reduction. Only the final beat of a window can carry
   // padding lanes; those are masked so they cannot win or raise NaN.
   always_comb begin
      is_first = (state_q == S_IDLE);
      cur_rem  = is_first ? rem_cur : rem_q;
      is_last  = is_first ? (beats_cur == CNT_W'(1))
                          : (beat_cnt_q == (beats_q - 1'b1));
      beat_key = KEY_MIN;
      beat_nan = 1'b0;
      lane_val = '0;
      lane_key = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_val = in_data[DATA_WIDTH*i +: DATA_WIDTH];
         lane_key = to_key(lane_val);
         if (!is_last || (CNT_W'(i) < cur_rem)) begin
            if (is_nan(lane_val)) begin
               beat_nan = 1'b1;
            end
            if (lane_key > beat_key) begin
               beat_key = lane_key;
            end
         end
      end
      // acc_q sits at the minimum key in IDLE, so the merge is a no-op there.
      merged_key = (acc_q > beat_key) ? acc_q : beat_key;
      merged_nan = nan_q | beat_nan;
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      nan_d       = nan_q;
      beat_cnt_d  = beat_cnt_q;
      beats_d     = beats_q;
      rem_d       = rem_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (flush) begin
         // Any beat offered this cycle is dropped; a pending result survives.
         state_d    = S_IDLE;
         acc_d      = KEY_MIN;
         nan_d      = 1'b0;
         beat_cnt_d = '0;
      end else if (accept) begin
         if (is_last) begin
            // Same-cycle pop and load is legal: the load overrides the clear.
            out_data_d  = merged_nan ? QNAN : from_key(merged_key);
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
            acc_d       = KEY_MIN;
            nan_d       = 1'b0;
            beat_cnt_d  = '0;
         end else begin
            state_d    = S_ACCUM;
            acc_d      = merged_key;
            nan_d      = merged_nan;
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (is_first) begin
               beats_d = beats_cur;
               rem_d   = rem_cur;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= KEY_MIN;
         nan_q       <= 1'b0;
         beat_cnt_q  <= '0;
         beats_q     <= '0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         nan_q       <= nan_d;
         beat_cnt_q  <= beat_cnt_d;
         beats_q     <= beats_d;
         rem_q       <= rem_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
